ac_dac_fifo: RTL and testbench

AC_DAC_FIFO -- requirements
Module: ac_dac_fifo

---
 rtl/ac_dac_fifo_pkg.sv | 38 +++
 rtl/ac_pair_fifo.sv | 61 ++++++
 rtl/ac_dac_fifo.sv | 164 ++++++++++++++++
 tb/tb_ac_dac_fifo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_dac_fifo_pkg.sv
// Shared register map, bit positions and the L/R pair type for the audio DAC FIFO.
package ac_dac_fifo_pkg;

   localparam logic [1:0] ADDR_LEFT  = 2'd0;
   localparam logic [1:0] ADDR_RIGHT = 2'd1;
   localparam logic [1:0] ADDR_CTRL  = 2'd2;
   localparam logic [1:0] ADDR_IRQ   = 2'd3;

   localparam int STAT_OVF_BIT   = 16;
   localparam int STAT_UDF_BIT   = 17;
   localparam int STAT_FULL_BIT  = 18;
   localparam int STAT_EMPTY_BIT = 19;

   localparam int CTRL_FLUSH_BIT = 0;
   localparam int CTRL_CLEAR_BIT = 1;
   localparam int IRQ_EN_BIT     = 16;

   localparam int SAMPLE_MAX_W = 32;

   // Samples are carried sign-extended to the widest supported sample width.
   typedef struct packed {
      logic signed [SAMPLE_MAX_W-1:0] left;
      logic signed [SAMPLE_MAX_W-1:0] right;
   } pair_t;

   function automatic logic [31:0] status_word(input logic [15:0] level, input logic ovf,
                                               input logic udf, input logic full, input logic empty);
      logic [31:0] w;
      w                 = '0;
      w[15:0]           = level;
      w[STAT_OVF_BIT]   = ovf;
      w[STAT_UDF_BIT]   = udf;
      w[STAT_FULL_BIT]  = full;
      w[STAT_EMPTY_BIT] = empty;
      return w;
   endfunction

endpackage

// File: rtl/ac_pair_fifo.sv
// Circular store of L/R sample pairs with push/pop/flush and a pair-count level.
module ac_pair_fifo
   import ac_dac_fifo_pkg::*;
#(
   parameter int W     = 24,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             push_left,
   input  logic [W-1:0]             push_right,
   input  logic                     pop,
   input  logic                     flush,
   output logic [W-1:0]             head_left,
   output logic [W-1:0]             head_right,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty,
   output logic                     dropped
);

   localparam int AW = $clog2(DEPTH);

   logic [2*W-1:0] mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty   = (level == '0);
   assign full    = (level == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty & ~flush;
   // A full FIFO still takes a push when a pop frees a slot in the same cycle.
   assign do_push = push & ~flush & (~full | do_pop);
   assign dropped = push & ~flush & ~do_push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      level <= level + 1'b1;
         else if (do_pop && !do_push) level <= level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {push_left, push_right};
   end

   assign {head_left, head_right} = mem[rd_ptr];

endmodule

// File: rtl/ac_dac_fifo.sv
// Avalon-MM fed sample-pair FIFO driving a stereo DAC on ready-edge handshakes.
// Optional level-threshold interrupt is built when AC_DAC_FIFO_IRQ_EN is defined.
module ac_dac_fifo
   import ac_dac_fifo_pkg::*;
#(
   parameter int DATA_WDT = 24,
   parameter int DEPTH    = 64
) (
   input  logic                mstClk,
   input  logic                mstReset,
   input  logic [1:0]          avsAdr,
   input  logic                avsWr,
   input  logic [31:0]         avsWrData,
   input  logic                avsRd,
   output logic [31:0]         avsRdData,
   input  logic                dacLRdy,
   output logic [DATA_WDT-1:0] dacLData,
   input  logic                dacRRdy,
   output logic [DATA_WDT-1:0] dacRData,
   output logic                irq
);

   localparam int LW = $clog2(DEPTH) + 1;

   logic [DATA_WDT-1:0] staged_left;
   pair_t               push_pair;
   logic                wr_left;
   logic                push;
   logic                ctrl_wr;
   logic                flush;
   logic                clear;
   logic                l_rdy_q;
   logic                r_rdy_q;
   logic                l_used;
   logic                r_used;
   logic                load;
   logic [DATA_WDT-1:0] head_left;
   logic [DATA_WDT-1:0] head_right;
   logic [LW-1:0]       level;
   logic                full;
   logic                empty;
   logic                dropped;
   logic                ovf;
   logic                udf;
   logic [31:0]         irq_word;
   logic [31:0]         rd_mux;

   assign wr_left = avsWr & (avsAdr == ADDR_LEFT);
   assign push    = avsWr & (avsAdr == ADDR_RIGHT);
   assign ctrl_wr = avsWr & (avsAdr == ADDR_CTRL);
   assign flush   = ctrl_wr & avsWrData[CTRL_FLUSH_BIT];
   assign clear   = ctrl_wr & avsWrData[CTRL_CLEAR_BIT];
   assign load    = l_used & r_used;

   assign push_pair.left  = SAMPLE_MAX_W'(signed'(staged_left));
   assign push_pair.right = SAMPLE_MAX_W'(signed'(avsWrData[DATA_WDT-1:0]));

   ac_pair_fifo #(
      .W     (DATA_WDT),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (mstClk),
      .rst_n      (mstReset),
      .push       (push),
      .push_left  (push_pair.left[DATA_WDT-1:0]),
      .push_right (push_pair.right[DATA_WDT-1:0]),
      .pop        (load),
      .flush      (flush),
      .head_left  (head_left),
      .head_right (head_right),
      .level      (level),
      .full       (full),
      .empty      (empty),
      .dropped    (dropped)
   );

   always_ff @(posedge mstClk or negedge mstReset) begin
      if (!mstReset) begin
         staged_left <= '0;
      end else if (wr_left) begin
         staged_left <= avsWrData[DATA_WDT-1:0];
      end
   end

   // The driver signals consumption of each channel independently; load once both are used.
   always_ff @(posedge mstClk or negedge mstReset) begin
      if (!mstReset) begin
         l_rdy_q <= 1'b0;
         r_rdy_q <= 1'b0;
         l_used  <= 1'b0;
         r_used  <= 1'b0;
      end else begin
         l_rdy_q <= dacLRdy;
         r_rdy_q <= dacRRdy;
         l_used  <= (l_used & ~load) | (dacLRdy & ~l_rdy_q);
         r_used  <= (r_used & ~load) | (dacRRdy & ~r_rdy_q);
      end
   end

   always_ff @(posedge mstClk or negedge mstReset) begin
      if (!mstReset) begin
         dacLData <= '0;
         dacRData <= '0;
      end else if (load) begin
         dacLData <= empty ? '0 : head_left;
         dacRData <= empty ? '0 : head_right;
      end
   end

   always_ff @(posedge mstClk or negedge mstReset) begin
      if (!mstReset) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else if (clear) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (dropped)       ovf <= 1'b1;
         if (load && empty) udf <= 1'b1;
      end
   end

`ifdef AC_DAC_FIFO_IRQ_EN
   logic [15:0] irq_thr;
   logic        irq_en;

   always_ff @(posedge mstClk or negedge mstReset) begin
      if (!mstReset) begin
         irq_thr <= '0;
         irq_en  <= 1'b0;
         irq     <= 1'b0;
      end else begin
         if (avsWr && (avsAdr == ADDR_IRQ)) begin
            irq_thr <= avsWrData[15:0];
            irq_en  <= avsWrData[IRQ_EN_BIT];
         end
         irq <= irq_en & (16'(level) < irq_thr);
      end
   end

   assign irq_word = {15'b0, irq_en, irq_thr};
`else
   assign irq      = 1'b0;
   assign irq_word = '0;
`endif

   always_comb begin
      rd_mux = '0;
      case (avsAdr)
         ADDR_CTRL: rd_mux = status_word(16'(level), ovf, udf, full, empty);
         ADDR_IRQ:  rd_mux = irq_word;
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge mstClk or negedge mstReset) begin
      if (!mstReset) begin
         avsRdData <= '0;
      end else if (avsRd) begin
         avsRdData <= rd_mux;
      end
   end

endmodule

// File: tb/tb_ac_dac_fifo.sv
// Directed-plus-random bench for ac_dac_fifo against a queue-based pair model.
module tb_ac_dac_fifo;

   localparam int W = 24;
   localparam int D = 64;

   logic          clk = 1'b0;
   logic          mstReset;
   logic [1:0]    avsAdr;
   logic          avsWr;
   logic [31:0]   avsWrData;
   logic          avsRd;
   logic [31:0]   avsRdData;
   logic          dacLRdy;
   logic [W-1:0]  dacLData;
   logic          dacRRdy;
   logic [W-1:0]  dacRData;
   logic          irq;

   int tests = 0;
   int fails = 0;

   logic [W-1:0] ql[$];
   logic [W-1:0] qr[$];
   logic [W-1:0] exp_l = '0;
   logic [W-1:0] exp_r = '0;
   logic [W-1:0] m_staged = '0;
   logic         m_ovf = 1'b0;
   logic         m_udf = 1'b0;
   logic         irq_on;

   ac_dac_fifo #(.DATA_WDT(W), .DEPTH(D)) dut (
      .mstClk    (clk),
      .mstReset  (mstReset),
      .avsAdr    (avsAdr),
      .avsWr     (avsWr),
      .avsWrData (avsWrData),
      .avsRd     (avsRd),
      .avsRdData (avsRdData),
      .dacLRdy   (dacLRdy),
      .dacLData  (dacLData),
      .dacRRdy   (dacRRdy),
      .dacRData  (dacRData),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      int n;
      n = ql.size();
      return {12'b0, (n == 0), (n == D), m_udf, m_ovf, 16'(n)};
   endfunction

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      avsAdr = a; avsWr = 1'b1; avsWrData = d;
      @(posedge clk); #1;
      avsWr = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      avsAdr = a; avsRd = 1'b1;
      @(posedge clk); #1;
      avsRd = 1'b0;
      d = avsRdData;
   endtask

   task automatic check_status(input string tag);
      logic [31:0] d;
      bus_rd(2'd2, d);
      check(tag, 64'(d), 64'(exp_status()));
   endtask

   task automatic model_push(input logic [W-1:0] r);
      if (ql.size() < D) begin
         ql.push_back(m_staged);
         qr.push_back(r);
      end else begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
      bus_wr(2'd0, 32'(l));
      m_staged = l;
      bus_wr(2'd1, 32'(r));
      model_push(r);
   endtask

   task automatic push_rand();
      push_pair(W'($urandom()), W'($urandom()));
   endtask

   // Both ready edges, optionally with a bus write landing in the load cycle.
   task automatic frame_op(input string tag, input logic do_wr, input logic [1:0] a, input logic [31:0] d);
      @(negedge clk) dacLRdy = 1'b1;
      @(negedge clk) dacRRdy = 1'b1;
      @(posedge clk); #1;
      check({tag, "_hold"}, 64'({dacLData, dacRData}), 64'({exp_l, exp_r}));
      dacLRdy = 1'b0; dacRRdy = 1'b0;
      if (do_wr) begin
         avsAdr = a; avsWr = 1'b1; avsWrData = d;
      end
      @(posedge clk); #1;
      avsWr = 1'b0;
      if (ql.size() > 0) begin
         exp_l = ql.pop_front();
         exp_r = qr.pop_front();
      end else begin
         exp_l = '0; exp_r = '0;
         m_udf = 1'b1;
      end
      if (do_wr && a == 2'd1) model_push(d[W-1:0]);
      if (do_wr && a == 2'd2 && d[1]) begin
         m_ovf = 1'b0; m_udf = 1'b0;
      end
      check(tag, 64'({dacLData, dacRData}), 64'({exp_l, exp_r}));
   endtask

   task automatic frame(input string tag);
      frame_op(tag, 1'b0, 2'd0, 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] held;
      int n;
      int m;
`ifdef AC_DAC_FIFO_IRQ_EN
      irq_on = 1'b1;
`else
      irq_on = 1'b0;
`endif
      mstReset = 1'b0;
      avsAdr = '0; avsWr = 1'b0; avsWrData = '0; avsRd = 1'b0;
      dacLRdy = 1'b0; dacRRdy = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outputs", 64'({dacLData, dacRData}), 64'd0);
      check("rst_rddata", 64'(avsRdData), 64'd0);
      check("rst_irq", 64'(irq), 64'd0);
      mstReset = 1'b1;
      check_status("rst_status");

      push_pair(24'h123456, 24'hFEDCBA);
      check_status("basic_level1");
      frame("basic_out");
      check_status("basic_level0");

      for (int round = 0; round < 4; round++) begin
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) push_rand();
         check_status("rand_fill");
         m = $urandom_range(1, n + 2);
         for (int i = 0; i < m; i++) frame("rand_out");
         check_status("rand_drain");
      end

      for (int i = 0; i < 3; i++) push_rand();
      bus_rd(2'd2, held);
      push_rand();
      @(negedge clk);
      check("rd_hold", 64'(avsRdData), 64'(held));

      bus_wr(2'd2, 32'h1);
      ql.delete(); qr.delete();
      check_status("flush_level");
      check("flush_out_kept", 64'({dacLData, dacRData}), 64'({exp_l, exp_r}));
      bus_wr(2'd2, 32'h2);
      m_ovf = 1'b0; m_udf = 1'b0;
      check_status("clear_flags");

      for (int i = 0; i < D + 1; i++) push_rand();
      check_status("overflow_full");
      bus_wr(2'd2, 32'h2);
      m_ovf = 1'b0; m_udf = 1'b0;
      bus_wr(2'd0, 32'h0A0B0C);
      m_staged = 24'h0A0B0C;
      frame_op("full_pushpop", 1'b1, 2'd1, 32'h00C0FFEE);
      check_status("full_pushpop_status");
      for (int i = 0; i < D; i++) frame("drain_out");
      check_status("drain_empty");
      frame("underflow_out");
      check_status("underflow_status");
      bus_wr(2'd2, 32'h2);
      m_ovf = 1'b0; m_udf = 1'b0;
      check_status("underflow_cleared");

      for (int i = 0; i < 5; i++) push_rand();
      bus_wr(2'd3, 32'h0001_0004);
      bus_rd(2'd3, d);
      check("irq_reg_read", 64'(d), irq_on ? 64'h0001_0004 : 64'd0);
      @(posedge clk); #1;
      check("irq_level5", 64'(irq), 64'd0);
      frame("irq_pop1");
      frame("irq_pop2");
      @(posedge clk); #1;
      check("irq_level3", 64'(irq), 64'(irq_on));
      push_rand();
      push_rand();
      @(posedge clk); #1;
      check("irq_refilled", 64'(irq), 64'd0);

      bus_wr(2'd2, 32'h1);
      ql.delete(); qr.delete();
      frame_op("clear_vs_udf", 1'b1, 2'd2, 32'h2);
      check_status("clear_vs_udf_status");

      for (int i = 0; i < 11; i++) push_rand();
      frame("pre_reset_out");
      check_status("pre_reset_level");
      @(negedge clk) dacLRdy = 1'b1;
      @(negedge clk) dacLRdy = 1'b0;
      #2 mstReset = 1'b0;
      #1;
      check("midrst_outputs", 64'({dacLData, dacRData}), 64'd0);
      check("midrst_rddata", 64'(avsRdData), 64'd0);
      check("midrst_irq", 64'(irq), 64'd0);
      @(negedge clk) mstReset = 1'b1;
      ql.delete(); qr.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_staged = '0;
      exp_l = '0; exp_r = '0;
      check_status("postrst_status");
      bus_rd(2'd3, d);
      check("postrst_irq_reg", 64'(d), 64'd0);
      @(negedge clk) dacRRdy = 1'b1;
      @(negedge clk) dacRRdy = 1'b0;
      repeat (2) @(negedge clk);
      check_status("postrst_no_load");
      @(negedge clk) dacLRdy = 1'b1;
      @(negedge clk) dacLRdy = 1'b0;
      repeat (2) @(negedge clk);
      m_udf = 1'b1;
      check_status("postrst_underflow");
      check("postrst_outputs", 64'({dacLData, dacRData}), 64'd0);
      bus_wr(2'd1, 32'h00654321);
      model_push(24'h654321);
      frame("postrst_staged_zero");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
